// File: rtl/uart_rx_if.sv
// Bundle of the receiver's serial input, read strobe and parallel result.
//   rx         : serial line (idle high), asynchronous to the receiver clock
//   rd_en      : consumer read strobe
//   data_out   : last correctly framed byte
//   data_valid : data_out holds an unread byte
//   frame_err  : one-cycle pulse on a bad stop bit
//   overrun    : sticky, a byte completed while data_valid was already high
//   busy       : receiver FSM is not idle
// slave is the receiver's view; master is the line driver / consumer's view.
interface uart_rx_if;
  logic       rx;
  logic       rd_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport slave (
    input  rx,
    input  rd_en,
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport master (
    output rx,
    output rd_en,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, idle-high line.
// The line is synchronised, a falling edge starts a frame, and each bit is
// sampled at its middle. The recovered byte is held on a valid/read handshake
// with sticky overrun and a one-cycle framing-error pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : uart_rx_if.slave (rx, rd_en in; data_out, data_valid, frame_err,
//           overrun, busy out)
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input logic     clk,
  input logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
  localparam int unsigned TimerW  = $clog2(CLKS_PER_BIT);

  typedef logic [TimerW-1:0] timer_t;

  localparam timer_t HalfLast = timer_t'(HalfBit - 1);
  localparam timer_t BitLast  = timer_t'(CLKS_PER_BIT - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  // Synchroniser. Stages reset to 1 so the line looks idle out of reset.
  logic [SYNC_STAGES-1:0] sync_q;
  // Tracks which stages (and rx_prev_q) hold real line samples since reset, so
  // a line already low at reset release is never mistaken for a falling edge.
  logic [SYNC_STAGES:0]   fill_q;
  logic                   rx_prev_q;
  logic                   rx_s;
  logic                   rx_fall;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_fall = fill_q[SYNC_STAGES] & rx_prev_q & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      fill_q    <= '0;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.rx};
      fill_q    <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      rx_prev_q <= rx_s;
    end
  end

  // Frame FSM
  logic [2:0] state_q, state_d;
  timer_t     timer_q, timer_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       good_stop;
  logic       bad_stop;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + timer_t'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (rx_fall) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (timer_q == HalfLast) begin
          timer_d   = '0;
          bit_idx_d = '0;
          // A line back high at mid start bit was only a glitch.
          state_d   = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (timer_q == BitLast) begin
          timer_d           = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d         = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          if (rx_s) begin
            good_stop = 1'b1;
            state_d   = StIdle;
          end else begin
            bad_stop = 1'b1;
            state_d  = StBreak;
          end
        end
      end
      StBreak: begin
        timer_d = '0;
        // Hold here while the line stays low so a break yields one error only.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Output holding registers and handshake
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic       rd_hit;

  assign rd_hit = bus.rd_en & valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = bad_stop;
    if (good_stop) begin
      // Newest byte always wins; a read on the same edge consumes the old one.
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !bus.rd_en) begin
        ovr_d = 1'b1;
      end else if (rd_hit) begin
        ovr_d = 1'b0;
      end
    end else if (rd_hit) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = ovr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;
  localparam int unsigned Cpb  = 16;
  localparam int unsigned Sync = 2;
  localparam int unsigned Half = Cpb / 2;
  // Edges from driving the start bit to data_valid being visible:
  // synchroniser delay + stop sample point + one update edge.
  localparam int Latency = Sync + Half + 9 * Cpb + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_if bus ();

  uart_rx_deserializer #(
    .CLKS_PER_BIT(Cpb),
    .SYNC_STAGES (Sync)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: edge count, frame_err pulses, data_valid rise edge
  int   edge_cnt  = 0;
  int   fe_cnt    = 0;
  int   fe_wide   = 0;
  int   rise_edge = -1;
  logic fe_prev   = 1'b0;
  logic dv_prev   = 1'b0;

  always @(posedge clk) begin
    edge_cnt++;
    #1;
    if (bus.frame_err === 1'b1) begin
      fe_cnt++;
      if (fe_prev === 1'b1) fe_wide++;
    end
    fe_prev = bus.frame_err;
    if (bus.data_valid === 1'b1 && dv_prev !== 1'b1) rise_edge = edge_cnt;
    dv_prev = bus.data_valid;
  end

  // Reference model: the receiver's visible state after each frame / read
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;
  int         m_fe    = 0;

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      if (m_valid) m_ovr = 1'b1;
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_fe++;
    end
  endfunction

  // Called at a negedge; returns at the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = bits[i];
      repeat (Cpb) @(negedge clk);
    end
    bus.rx = 1'b1;
    model_frame(b, stop_ok);
  endtask

  task automatic do_read();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.rx    = 1'b1;
    bus.rd_en = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.overrun, bus.frame_err, bus.busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b o=%b fe=%b busy=%b, exp all 0",
               bus.data_out, bus.data_valid, bus.overrun, bus.frame_err, bus.busy);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if ({bus.data_valid, bus.busy, bus.frame_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_idle: got v=%b busy=%b fe=%b, exp 0 0 0",
               bus.data_valid, bus.busy, bus.frame_err);
    end
  endtask

  task automatic test_basic();
    int start;
    rise_edge = -1;
    start     = edge_cnt;
    send_frame(8'hA5, 1'b1);
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.overrun} !== {m_data, m_valid, m_ovr}) begin
      n_fail++;
      $display("FAIL basic_state: got data=%h v=%b o=%b exp data=%h v=%b o=%b",
               bus.data_out, bus.data_valid, bus.overrun, m_data, m_valid, m_ovr);
    end
    n_tests++;
    if (rise_edge - start !== Latency) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges exp %0d", rise_edge - start, Latency);
    end
    n_tests++;
    if (fe_cnt !== m_fe) begin
      n_fail++;
      $display("FAIL basic_frame_err: got %0d pulses exp %0d", fe_cnt, m_fe);
    end
    do_read();
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.overrun} !== {m_data, m_valid, m_ovr}) begin
      n_fail++;
      $display("FAIL basic_read_clear: got data=%h v=%b o=%b exp data=%h v=%b o=%b",
               bus.data_out, bus.data_valid, bus.overrun, m_data, m_valid, m_ovr);
    end
  endtask

  task automatic test_glitch();
    rise_edge = -1;
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy: got %b exp 1", bus.busy);
    end
    bus.rx = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.data_valid} !== 2'b00 || rise_edge != -1 || fe_cnt != m_fe) begin
      n_fail++;
      $display("FAIL glitch_no_output: got busy=%b v=%b rise=%0d fe=%0d exp 0 0 -1 %0d",
               bus.busy, bus.data_valid, rise_edge, fe_cnt, m_fe);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0);
    repeat (Sync + 3) @(negedge clk);
    n_tests++;
    if (fe_cnt !== m_fe || fe_wide !== 0) begin
      n_fail++;
      $display("FAIL ferr_pulse: got pulses=%0d wide=%0d exp %0d 0", fe_cnt, fe_wide, m_fe);
    end
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.overrun, bus.busy} !==
        {m_data, m_valid, m_ovr, 1'b0}) begin
      n_fail++;
      $display("FAIL ferr_hold: got data=%h v=%b o=%b busy=%b exp data=%h v=%b o=%b busy=0",
               bus.data_out, bus.data_valid, bus.overrun, bus.busy, m_data, m_valid, m_ovr);
    end
    send_frame(8'h81, 1'b1);
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.overrun} !== {m_data, m_valid, m_ovr}) begin
      n_fail++;
      $display("FAIL ferr_recover: got data=%h v=%b o=%b exp data=%h v=%b o=%b",
               bus.data_out, bus.data_valid, bus.overrun, m_data, m_valid, m_ovr);
    end
    do_read();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.overrun} !== {m_data, m_valid, m_ovr}) begin
      n_fail++;
      $display("FAIL overrun_set: got data=%h v=%b o=%b exp data=%h v=%b o=%b",
               bus.data_out, bus.data_valid, bus.overrun, m_data, m_valid, m_ovr);
    end
    do_read();
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.overrun} !== {m_data, m_valid, m_ovr}) begin
      n_fail++;
      $display("FAIL overrun_clear: got data=%h v=%b o=%b exp data=%h v=%b o=%b",
               bus.data_out, bus.data_valid, bus.overrun, m_data, m_valid, m_ovr);
    end
  endtask

  task automatic test_simul_read();
    fork
      begin
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
      end
      begin
        // rd_en high across the second frame's completion edge
        repeat (10 * Cpb + Latency - 1) @(negedge clk);
        do_read();
      end
    join
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.overrun} !== {m_data, m_valid, m_ovr}) begin
      n_fail++;
      $display("FAIL simul_read: got data=%h v=%b o=%b exp data=%h v=%b o=%b",
               bus.data_out, bus.data_valid, bus.overrun, m_data, m_valid, m_ovr);
    end
    do_read();
  endtask

  task automatic test_reset_mid();
    int fe0;
    int start;
    // 0xF0: start and data bits 0..3 are all low; stop midway through bit 3
    bus.rx = 1'b0;
    repeat (4 * Cpb + Half) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_busy_before: got %b exp 1", bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.overrun, bus.frame_err, bus.busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL midreset_outputs: got data=%h v=%b o=%b fe=%b busy=%b, exp all 0",
               bus.data_out, bus.data_valid, bus.overrun, bus.frame_err, bus.busy);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    fe0       = fe_cnt;
    rise_edge = -1;
    repeat (3 * Cpb) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || rise_edge != -1) begin
      n_fail++;
      $display("FAIL midreset_low_line: got busy=%b rise=%0d exp 0 -1", bus.busy, rise_edge);
    end
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    start = edge_cnt;
    send_frame(8'h5A, 1'b1);
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.overrun} !== {m_data, m_valid, m_ovr} ||
        fe_cnt != fe0 || rise_edge - start != Latency) begin
      n_fail++;
      $display("FAIL midreset_next: got data=%h v=%b o=%b fe=%0d rise=%0d exp %h %b %b %0d %0d",
               bus.data_out, bus.data_valid, bus.overrun, fe_cnt - fe0, rise_edge - start,
               m_data, m_valid, m_ovr, 0, Latency);
    end
    do_read();
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         ok;
    int         gap;
    for (int i = 0; i < 20; i++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      gap = ok ? int'($urandom_range(0, 2 * Cpb)) : int'($urandom_range(Cpb, 2 * Cpb));
      send_frame(b, ok);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 1) == 1) do_read();
      n_tests++;
      if ({bus.data_out, bus.data_valid, bus.overrun} !== {m_data, m_valid, m_ovr} ||
          fe_cnt != m_fe) begin
        n_fail++;
        $display("FAIL random_%0d: got data=%h v=%b o=%b fe=%0d exp data=%h v=%b o=%b fe=%0d",
                 i, bus.data_out, bus.data_valid, bus.overrun, fe_cnt,
                 m_data, m_valid, m_ovr, m_fe);
      end
    end
    n_tests++;
    if (fe_wide !== 0) begin
      n_fail++;
      $display("FAIL random_ferr_width: got %0d wide pulses exp 0", fe_wide);
    end
  endtask

  initial begin
    bus.rx    = 1'b1;
    bus.rd_en = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_simul_read();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
